// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//   Shares one combinational ALU between two requesters. It arbitrates
//   valid/ready requests, registers the winning operands onto the ALU,
//   holds them there for EXEC_CYCLES cycles, captures the result and flags,
//   and returns them on a single response channel tagged with the id of the
//   requester.
//
//   Parameters
//     WIDTH        operand/result width (must match the attached ALU, 4)
//     EXEC_CYCLES  cycles the operands sit on the ALU before capture (>= 1)
//
//   Optional build macro
//     ALU_SHARE_FIXED_PRIO_EN  requester 0 always wins when both are valid;
//                              default (undefined) is round-robin.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     req_valid[1:0]  in        per-requester op valid
//     req_ready[1:0]  out       per-requester accept (one-hot or zero)
//     req_f[5:0]      in        function codes {req1, req0}
//     req_a, req_b    in        operands {req1, req0}
//     alu_f/a/b       out       registered operands towards the ALU
//     alu_out/zero/overflow/carry in  ALU result and flags
//     rsp_valid/ready           response handshake
//     rsp_id                    requester id of the response
//     rsp_out/zero/overflow/carry   captured result and flags
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [5:0]           req_f,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic [2:0]           alu_f,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_out,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 rsp_carry
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2:0]         op_f_q, op_f_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_id_q, op_id_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_out_q, rsp_out_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_carry_q, rsp_carry_d;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic               last_grant_q, last_grant_d;
`endif

  logic               grant_vld;
  logic               grant_id;
  logic               accept;
  logic [2:0]         sel_f;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Arbitration: recomputed every cycle, nothing is locked until accept.
  always_comb begin
    grant_vld = |req_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    grant_id  = ~req_valid[0];
`else
    if (&req_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~req_valid[0];
    end
`endif
  end

  assign req_ready = (state_q == S_IDLE && grant_vld) ? {grant_id, ~grant_id} : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_f = grant_id ? req_f[5:3]               : req_f[2:0];
    sel_a = grant_id ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
    sel_b = grant_id ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_f_d       = op_f_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_carry_d  = rsp_carry_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_f_d       = sel_f;
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          op_id_d      = grant_id;
`ifndef ALU_SHARE_FIXED_PRIO_EN
          last_grant_d = grant_id;
`endif
          cnt_d        = CNT_LOAD;
          state_d      = S_EXEC;
        end
      end

      S_EXEC: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = op_id_q;
          rsp_out_d   = alu_out;
          rsp_zero_d  = alu_zero;
          rsp_ovf_d   = alu_overflow;
          rsp_carry_d = alu_carry;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        // Returning straight to IDLE (not accepting here) gives the
        // one-cycle bubble after every response handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_f_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_carry_q  <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_f_q       <= op_f_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_carry_q  <= rsp_carry_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // The ALU sees the operand registers in every state; they only move on accept.
  assign alu_f        = op_f_q;
  assign alu_a        = op_a_q;
  assign alu_b        = op_b_q;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_out      = rsp_out_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_carry    = rsp_carry_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Bench for alu_share_ctrl: a directed table of single requests, hand
//   sequences for arbitration, back-pressure, reset mid-operation and a
//   3-cycle EXEC instance, then random traffic against a transaction model.
//   A small stand-in ALU answers the DUT's alu_* outputs.
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int E1 = 1;
  localparam int E3 = 3;
`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req_valid, req_ready;
  logic [5:0] req_f;
  logic [7:0] req_a, req_b;
  logic [2:0] alu_f;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_zero, rsp_overflow, rsp_carry;

  logic [1:0] d3_req_valid, d3_req_ready;
  logic [5:0] d3_req_f;
  logic [7:0] d3_req_a, d3_req_b;
  logic [2:0] d3_alu_f;
  logic [3:0] d3_alu_a, d3_alu_b, d3_alu_out;
  logic       d3_alu_zero, d3_alu_overflow, d3_alu_carry;
  logic       d3_rsp_valid, d3_rsp_ready, d3_rsp_id;
  logic [3:0] d3_rsp_out;
  logic       d3_rsp_zero, d3_rsp_overflow, d3_rsp_carry;

  typedef struct packed {
    logic [3:0] out;
    logic       zero;
    logic       ovf;
    logic       carry;
  } res_t;

  // Stand-in ALU. The controller passes flags through untouched, so the
  // flag definitions only need to be deterministic and distinct.
  function automatic res_t alu_model(input logic [2:0] f, input logic [3:0] a,
                                     input logic [3:0] b);
    res_t r;
    logic [4:0] s;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (f)
      3'b000: begin
        r.out   = s[3:0];
        r.carry = s[4];
        r.ovf   = s[4] | ((a[3] == b[3]) && (s[3] != a[3]));
      end
      3'b001: begin
        r.out   = a - b;
        r.carry = (a < b);
        r.ovf   = (a[3] != b[3]) && (r.out[3] != a[3]);
      end
      3'b010: r.out = a | b;
      3'b011: r.out = a & b;
      3'b100: r.out = a ^ b;
      3'b101: r.out = ~a;
      3'b110: begin
        r.out   = {a[2:0], 1'b0};
        r.carry = a[3];
      end
      default: r.out = b;
    endcase
    r.zero = (r.out == 4'h0);
    return r;
  endfunction

  res_t alu_r, d3_alu_r;
  assign alu_r           = alu_model(alu_f, alu_a, alu_b);
  assign alu_out         = alu_r.out;
  assign alu_zero        = alu_r.zero;
  assign alu_overflow    = alu_r.ovf;
  assign alu_carry       = alu_r.carry;
  assign d3_alu_r        = alu_model(d3_alu_f, d3_alu_a, d3_alu_b);
  assign d3_alu_out      = d3_alu_r.out;
  assign d3_alu_zero     = d3_alu_r.zero;
  assign d3_alu_overflow = d3_alu_r.ovf;
  assign d3_alu_carry    = d3_alu_r.carry;

  alu_share_ctrl #(.WIDTH(4), .EXEC_CYCLES(E1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_f(req_f), .req_a(req_a), .req_b(req_b),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry)
  );

  alu_share_ctrl #(.WIDTH(4), .EXEC_CYCLES(E3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready),
    .req_f(d3_req_f), .req_a(d3_req_a), .req_b(d3_req_b),
    .alu_f(d3_alu_f), .alu_a(d3_alu_a), .alu_b(d3_alu_b),
    .alu_out(d3_alu_out), .alu_zero(d3_alu_zero),
    .alu_overflow(d3_alu_overflow), .alu_carry(d3_alu_carry),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_out(d3_rsp_out), .rsp_zero(d3_rsp_zero),
    .rsp_overflow(d3_rsp_overflow), .rsp_carry(d3_rsp_carry)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [2:0] f, input logic [3:0] a,
                           input logic [3:0] b);
    req_valid[id]    = 1'b1;
    req_f[id*3 +: 3] = f;
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
  endtask

  // Entered at a negedge with the request driven; leaves at the negedge
  // after the accepting edge with that requester's valid dropped.
  task automatic accept(input int id);
    int n;
    n = 0;
    #1;
    while (!(req_valid[id] && req_ready[id]) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("accept_req%0d", id), 32'(req_ready[id]), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  // Counts negedges with rsp_valid low; equals EXEC_CYCLES after accept().
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_rsp(input string nm, input int id, input int o, input int z,
                         input int v, input int c);
    chk({nm, "_valid"}, 32'(rsp_valid), 1);
    chk({nm, "_id"},    32'(rsp_id), id);
    chk({nm, "_out"},   32'(rsp_out), o);
    chk({nm, "_zero"},  32'(rsp_zero), z);
    chk({nm, "_ovf"},   32'(rsp_overflow), v);
    chk({nm, "_carry"}, 32'(rsp_carry), c);
  endtask

  typedef struct packed {
    logic       id;
    logic [2:0] f;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       z;
    logic       o;
    logic       c;
  } vec_t;

  vec_t vec[12];

  // random-phase model state
  bit         pend[2];
  logic [2:0] pf[2];
  logic [3:0] pa[2], pb[2];
  bit         inflight;
  int         rsp_from, last, g, exp_id, lat;
  logic [2:0] ef;
  logic [3:0] ea, eb;
  res_t       er;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b0, 3'b000, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 3'b001, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 3'b000, 4'h7, 4'h9, 4'h0, 1'b1, 1'b1, 1'b1};
    vec[3]  = '{1'b1, 3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 3'b001, 4'h2, 4'h5, 4'hD, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b1, 3'b010, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 3'b100, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 3'b000, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 3'b110, 4'h9, 4'h0, 4'h2, 1'b0, 1'b0, 1'b1};
    vec[9]  = '{1'b1, 3'b111, 4'h0, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 3'b101, 4'hA, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    req_valid = '0; req_f = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    d3_req_valid = '0; d3_req_f = '0; d3_req_a = '0; d3_req_b = '0; d3_rsp_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_alu_f", 32'(alu_f), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // single-requester table
    for (int i = 0; i < 12; i++) begin
      drive_req(int'(vec[i].id), vec[i].f, vec[i].a, vec[i].b);
      accept(int'(vec[i].id));
      chk($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vec[i].a));
      chk($sformatf("v%0d_alu_b", i), 32'(alu_b), 32'(vec[i].b));
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), E1);
      chk_rsp($sformatf("v%0d", i), int'(vec[i].id), int'(vec[i].out), int'(vec[i].z),
              int'(vec[i].o), int'(vec[i].c));
      @(negedge clk);
      chk($sformatf("v%0d_valid_1cyc", i), 32'(rsp_valid), 0);
    end

    // both valid: last grant was requester 1, so requester 0 goes first
    drive_req(0, 3'b001, 4'h5, 4'h5);
    drive_req(1, 3'b000, 4'h7, 4'h9);
    #1 chk("both_grant_first", 32'(req_ready), 1);
    accept(0);
    wait_rsp(lat);
    chk_rsp("both_r0", 0, 0, 1, 0, 0);
    @(negedge clk);
    accept(1);
    wait_rsp(lat);
    chk_rsp("both_r1", 1, 0, 1, 1, 1);
    @(negedge clk);
    drive_req(0, 3'b100, 4'h3, 4'h5);
    drive_req(1, 3'b010, 4'h8, 4'h1);
    #1 chk("next_round_grant", 32'(req_ready), 1);
    accept(0);
    wait_rsp(lat);
    chk_rsp("round2_r0", 0, 6, 0, 0, 0);
    @(negedge clk);
    // requester 1 still waiting, requester 0 comes back immediately
    drive_req(0, 3'b011, 4'hF, 4'h3);
    g = FIXED ? 0 : 1;
    #1 chk("round3_grant", 32'(req_ready), (g == 0) ? 1 : 2);
    accept(g);
    wait_rsp(lat);
    chk_rsp("round3_first", g, (g == 0) ? 3 : 9, 0, 0, 0);
    @(negedge clk);
    accept(1 - g);
    wait_rsp(lat);
    chk_rsp("round3_second", 1 - g, (g == 0) ? 9 : 3, 0, 0, 0);
    @(negedge clk);

    // back-pressure in RESP
    rsp_ready = 1'b0;
    drive_req(1, 3'b000, 4'h9, 4'h3);
    accept(1);
    drive_req(0, 3'b001, 4'h6, 4'h2);
    wait_rsp(lat);
    for (int k = 0; k < 5; k++) begin
      chk_rsp($sformatf("bp%0d", k), 1, 12, 0, 0, 0);
      chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("bp_release_ready", 32'(req_ready), 1);
    accept(0);
    wait_rsp(lat);
    chk_rsp("bp_next", 0, 4, 0, 0, 0);
    @(negedge clk);

    // reset while in EXEC drops the operation
    drive_req(0, 3'b000, 4'h2, 4'h2);
    accept(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rst_drop%0d", k), 32'(rsp_valid), 0);
      @(negedge clk);
    end
    chk("rst_drop_alu_a", 32'(alu_a), 0);
    drive_req(0, 3'b010, 4'h1, 4'h2);
    drive_req(1, 3'b100, 4'h4, 4'h4);
    #1 chk("post_rst_grant", 32'(req_ready), 1);
    accept(0);
    wait_rsp(lat);
    chk_rsp("post_rst_r0", 0, 3, 0, 0, 0);
    @(negedge clk);
    accept(1);
    wait_rsp(lat);
    chk_rsp("post_rst_r1", 1, 0, 1, 0, 0);
    @(negedge clk);

    // EXEC_CYCLES=3 instance
    d3_rsp_ready = 1'b1;
    d3_req_valid[1] = 1'b1;
    d3_req_f[5:3] = 3'b011;
    d3_req_a[7:4] = 4'hC;
    d3_req_b[7:4] = 4'hA;
    #1 chk("e3_ready", 32'(d3_req_ready), 2);
    @(posedge clk);
    @(negedge clk);
    d3_req_valid = '0;
    for (int k = 0; k < E3; k++) begin
      chk($sformatf("e3_wait%0d_valid", k), 32'(d3_rsp_valid), 0);
      chk($sformatf("e3_wait%0d_alu", k), 32'({d3_alu_f, d3_alu_a, d3_alu_b}),
          32'({3'b011, 4'hC, 4'hA}));
      @(negedge clk);
    end
    chk("e3_rsp_valid", 32'(d3_rsp_valid), 1);
    chk("e3_rsp_id", 32'(d3_rsp_id), 1);
    chk("e3_rsp_out", 32'(d3_rsp_out), 8);
    @(negedge clk);
    chk("e3_valid_1cyc", 32'(d3_rsp_valid), 0);
    chk("e3_alu_hold", 32'(d3_alu_a), 12);

    // random traffic against a transaction-level model
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    inflight = 1'b0; last = 1; rsp_from = 0; exp_id = 0;
    ef = '0; ea = '0; eb = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && $urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pf[i] = 3'($urandom);
          pa[i] = 4'($urandom);
          pb[i] = 4'($urandom);
        end
        req_valid[i] = pend[i];
        if (pend[i]) begin
          req_f[i*3 +: 3] = pf[i];
          req_a[i*4 +: 4] = pa[i];
          req_b[i*4 +: 4] = pb[i];
        end else begin
          req_f[i*3 +: 3] = 3'($urandom);
          req_a[i*4 +: 4] = 4'($urandom);
          req_b[i*4 +: 4] = 4'($urandom);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (!inflight) begin
        g = -1;
        if (pend[0] && pend[1]) g = (FIXED || last == 1) ? 0 : 1;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
        chk("rnd_grant", 32'(req_ready), (g < 0) ? 0 : ((g == 0) ? 1 : 2));
        chk("rnd_idle_valid", 32'(rsp_valid), 0);
        if (g >= 0) begin
          inflight = 1'b1;
          exp_id   = g;
          ef = pf[g]; ea = pa[g]; eb = pb[g];
          rsp_from = cyc + 1 + E1;
          last     = g;
          pend[g]  = 1'b0;
        end
      end else begin
        chk("rnd_busy_ready", 32'(req_ready), 0);
        if (cyc < rsp_from) begin
          chk("rnd_exec_valid", 32'(rsp_valid), 0);
          chk("rnd_exec_alu", 32'({alu_f, alu_a, alu_b}), 32'({ef, ea, eb}));
        end else begin
          chk("rnd_rsp_valid", 32'(rsp_valid), 1);
          if (rsp_ready) begin
            er = alu_model(ef, ea, eb);
            chk("rnd_rsp_id", 32'(rsp_id), exp_id);
            chk("rnd_rsp_res", 32'({rsp_out, rsp_zero, rsp_overflow, rsp_carry}), 32'(er));
            inflight = 1'b0;
          end
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
